// File: rtl/seat_request_queue.sv
// ---------------------------------------------------------------------------
// seat_request_queue
//
// Front-end of the school seating system. Kiosk and card-reader requests
// (student number, seat number, seat state) are checked for a legal seat
// number, buffered in a FIFO, and handed to the seating core one at a time.
// Each hand-off is a single-cycle write strobe. The data lines stay held
// until the next hand-off. The block also owns the time-of-day counter that
// drives the core's Time input.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset (synchronous release)
//   req_valid       request present
//   req_ready       queue can accept (not full)
//   req_student_no  student number of the request
//   req_seat_no     requested seat (1..NUM_SEATS valid)
//   req_seat_state  requested seat state
//   time_set        load the minute counter from time_set_val
//   time_set_val    minute value to load (values above 1439 clamp to 1439)
//   Student_No      student number to the seating core
//   Seat_No         seat number to the seating core
//   Seat_State      seat state to the seating core
//   write           one-cycle write strobe to the seating core
//   Time            minutes since midnight, 0..1439
//   drop_count      (SEAT_REQ_STATS_EN only) saturating count of invalid-seat drops
//   overflow_seen   (SEAT_REQ_STATS_EN only) sticky: request offered while full
//   busy            queue non-empty or issue FSM not idle
//
// Optional build macro: SEAT_REQ_STATS_EN adds the drop_count and
// overflow_seen statistics outputs.
// ---------------------------------------------------------------------------
module seat_request_queue #(
    parameter int DEPTH         = 8,
    parameter int NUM_SEATS     = 30,
    parameter int TICKS_PER_MIN = 6000,
    parameter int WRITE_GAP     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [24:0] req_student_no,
    input  logic [4:0]  req_seat_no,
    input  logic [1:0]  req_seat_state,
    input  logic        time_set,
    input  logic [10:0] time_set_val,
    output logic [24:0] Student_No,
    output logic [4:0]  Seat_No,
    output logic [1:0]  Seat_State,
    output logic        write,
    output logic [10:0] Time,
`ifdef SEAT_REQ_STATS_EN
    output logic [7:0]  drop_count,
    output logic        overflow_seen,
`endif
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
    localparam logic [10:0] LAST_MINUTE = 11'd1439;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request acceptance and validation
    // ------------------------------------------------------------------
    logic accept;
    logic seat_ok;
    logic push;
    logic pop;

    logic [CW-1:0] count_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    state_t        state_reg;
    state_t        state_next;
    logic [GW-1:0] gap_cnt_reg;
    logic [GW-1:0] gap_cnt_next;

    // Ready comes straight from the registered occupancy, so a pop in the
    // same cycle as a full queue does not open the door for that cycle.
    assign req_ready = (count_reg != CW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign seat_ok   = (req_seat_no != 5'd0) && ({27'd0, req_seat_no} <= NUM_SEATS);
    // Invalid seats still complete the handshake; they just never land in the FIFO.
    assign push      = accept && seat_ok;
    assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);

    // ------------------------------------------------------------------
    // FIFO storage: plain array, written on push, read into the output
    // holding registers on pop (registered read).
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {req_student_no, req_seat_no, req_seat_state};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output holding registers: loaded when the head is popped (entry to
    // ISSUE) and left alone until the next pop.
    // ------------------------------------------------------------------
    logic [24:0] student_reg;
    logic [4:0]  seat_reg;
    logic [1:0]  seat_state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            student_reg    <= '0;
            seat_reg       <= '0;
            seat_state_reg <= '0;
        end else if (pop) begin
            {student_reg, seat_reg, seat_state_reg} <= mem[rd_ptr_reg];
        end
    end

    assign Student_No = student_reg;
    assign Seat_No    = seat_reg;
    assign Seat_State = seat_state_reg;

    // ------------------------------------------------------------------
    // Issue FSM: IDLE -> ISSUE (strobe) -> HOLD (WRITE_GAP cycles) -> IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gap_cnt_next = '0;
                state_next   = (WRITE_GAP > 0) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (gap_cnt_reg == GW'(WRITE_GAP - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Decoded from the state register so reset removes the strobe at once.
    assign write = (state_reg == ST_ISSUE);
    assign busy  = (count_reg != '0) || (state_reg != ST_IDLE);

    // ------------------------------------------------------------------
    // Time of day: tick prescaler feeding a 0..1439 minute counter.
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_reg;
    logic [10:0]   time_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_reg <= '0;
            time_reg <= '0;
        end else if (time_set) begin
            tick_reg <= '0;
            time_reg <= (time_set_val > LAST_MINUTE) ? LAST_MINUTE : time_set_val;
        end else if (tick_reg == TW'(TICKS_PER_MIN - 1)) begin
            tick_reg <= '0;
            time_reg <= (time_reg == LAST_MINUTE) ? 11'd0 : time_reg + 11'd1;
        end else begin
            tick_reg <= tick_reg + TW'(1);
        end
    end

    assign Time = time_reg;

`ifdef SEAT_REQ_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [7:0] drop_count_reg;
    logic       overflow_seen_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_reg    <= '0;
            overflow_seen_reg <= 1'b0;
        end else begin
            if (accept && !seat_ok && (drop_count_reg != 8'hFF)) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end
            if (req_valid && !req_ready) begin
                overflow_seen_reg <= 1'b1;
            end
        end
    end

    assign drop_count    = drop_count_reg;
    assign overflow_seen = overflow_seen_reg;
`endif

endmodule
